// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, centre-sampled start/data/stop bits, byte + one-cycle valid strobe.
// Define UART_RX_MAJORITY_EN to make every bit decision a 2-of-3 vote over the last three synchronized samples.
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam logic [31:0] HALF = 32'((CLKS_PER_BIT - 1) / 2);
    localparam logic [31:0] LAST = 32'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        r_Rx;
    logic [31:0] count;
    logic [2:0]  bit_index;
    logic [7:0]  shift;
    logic        sample;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            r_Rx    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            r_Rx    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // rx_hist[0] is r_Rx one cycle back, rx_hist[1] two cycles back; decision counts are >= 3,
    // so the window never reaches across the previous state.
    logic [1:0] rx_hist;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_hist <= '1;
        end else begin
            rx_hist <= {rx_hist[0], r_Rx};
        end
    end

    always_comb begin
        sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & r_Rx) | (rx_hist[0] & r_Rx);
    end
`else
    always_comb begin
        sample = r_Rx;
    end
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= IDLE;
            count          <= '0;
            bit_index      <= '0;
            shift          <= '0;
            o_Rx_Byte      <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            o_Rx_DV        <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (!r_Rx) begin
                        state       <= START;
                        o_Rx_Active <= 1'b1;
                    end
                end
                START: begin
                    if (count == HALF) begin
                        count <= '0;
                        if (!sample) begin
                            state     <= DATA;
                            bit_index <= '0;
                        end else begin
                            state       <= IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                DATA: begin
                    if (count == LAST) begin
                        count            <= '0;
                        shift[bit_index] <= sample;
                        bit_index        <= bit_index + 3'd1;
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                STOP: begin
                    if (count == LAST) begin
                        count       <= '0;
                        o_Rx_Byte   <= shift;
                        o_Rx_Active <= 1'b0;
                        state       <= CLEANUP;
                        if (sample) begin
                            o_Rx_DV <= 1'b1;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                        end
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                CLEANUP: begin
                    // A low line here is a break; wait for it to go high so it cannot look like a new start bit.
                    count <= '0;
                    if (r_Rx) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: driver pushes expected bytes/errors and active-window lengths, monitor pops on output pulses.
module tb_uart_rx;

    localparam int CPB = 217;
    localparam int H   = (CPB - 1) / 2;
    localparam int STOP_LAT = 3 + H + 9 * CPB;

    typedef struct {
        logic [7:0]  data;
        logic        err;
        int unsigned due;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       active;
    logic       frame_err;

    exp_t        exp_q[$];
    int          run_q[$];
    int unsigned edge_cnt = 0;
    int unsigned run_len  = 0;
    int unsigned dv_cnt   = 0;
    int          passed   = 0;
    int          total    = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Active    (active),
        .o_Rx_Frame_Err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act == exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Called right after a falling edge; returns right after the falling edge that ends the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit glitch);
        logic [9:0] frame;
        exp_t       e;
        frame  = {stop_bit, b, 1'b0};
        e.data = b;
        e.err  = !stop_bit;
        e.due  = edge_cnt + 1 + STOP_LAT;
        exp_q.push_back(e);
        run_q.push_back(STOP_LAT - 2);
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            for (int j = 0; j < CPB; j++) begin
                if (glitch && i >= 1 && i <= 8 && j == H + 1) rx = ~frame[i];
                if (glitch && i >= 1 && i <= 8 && j == H + 2) rx = frame[i];
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (dv === 1'b1) dv_cnt = dv_cnt + 1;
        if (dv === 1'b1 || frame_err === 1'b1) begin
            chk("dv_err_exclusive", longint'(dv & frame_err), 0);
            chk("pulse_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rx_byte", rx_byte, e.data);
                chk("frame_err", frame_err, e.err);
                chk("pulse_edge", edge_cnt, e.due);
            end
        end
        if (active === 1'b1) begin
            run_len = run_len + 1;
        end else if (run_len != 0) begin
            chk("active_expected", longint'(run_q.size() != 0), 1);
            if (run_q.size() != 0) begin
                int e;
                e = run_q.pop_front();
                if (e >= 0) chk("active_len", run_len, e);
            end
            run_len = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] last_byte;
        logic [7:0] c3;
        int unsigned dv_before;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dv", dv, 0);
        chk("reset_byte", rx_byte, 0);
        chk("reset_active", active, 0);
        chk("reset_err", frame_err, 0);
        rst = 1'b0;

        idle(5000);
        chk("idle_no_dv", dv_cnt, 0);

        send_frame(8'hA5, 1'b1, 1'b0);
        idle(2 * CPB);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(2 * CPB);

        // False start: active from the edge after entry to START through the check edge.
        dv_before = dv_cnt;
        run_q.push_back(H + 1);
        rx = 1'b0;
        repeat (50) @(negedge clk);
        idle(2 * CPB);
        chk("false_start_no_dv", dv_cnt, dv_before);

        dv_before = dv_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3000) @(negedge clk);
        idle(2 * CPB);
        chk("break_no_dv", dv_cnt, dv_before);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(2 * CPB);

        // Reset halfway through data bit 4 of 8'hC3; the partial frame must vanish.
        dv_before = dv_cnt;
        c3 = 8'hC3;
        run_q.push_back(-1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            repeat (CPB) @(negedge clk);
        end
        rx = c3[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_byte", rx_byte, 0);
        chk("midreset_active", active, 0);
        rst = 1'b0;
        idle(2 * CPB);
        chk("midreset_no_dv", dv_cnt, dv_before);
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h81, 1'b1, 1'b1);
`else
        send_frame(8'h81, 1'b1, 1'b0);
`endif
        idle(CPB);

        last_byte = 8'h81;
        for (int n = 0; n < 6; n++) begin
            last_byte = 8'($urandom);
            send_frame(last_byte, 1'b1, 1'b0);
            idle($urandom_range(0, CPB));
        end

        for (int i = 0; i < 4 * CPB && (exp_q.size() != 0 || run_q.size() != 0); i++) begin
            @(negedge clk);
        end
        chk("pending_pulses", exp_q.size(), 0);
        chk("pending_active", run_q.size(), 0);
        chk("held_byte", rx_byte, last_byte);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver and counterpart of the team's 8N1 transmitter. It deserialises one start bit, 8 data bits (LSB first) and one stop bit from an asynchronous serial line into a byte with a one-cycle valid strobe. It sits between the FPGA pin and the command/byte-handling logic, and shares CLKS_PER_BIT with the transmitter so both ends run at the same baud.

## Interface
- CLKS_PER_BIT, default 217: clock cycles per bit, i_Clock freq / baud; must be ≥ 8.
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line; idles high.
- o_Rx_DV  out  1  one-cycle pulse; o_Rx_Byte holds a valid byte.
- o_Rx_Byte  out  8  last received byte; held until the next frame completes.
- o_Rx_Active  out  1  high while a frame is being received (START through STOP).
- o_Rx_Frame_Err  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- i_Rx_Serial passes through a 2-FF synchronizer (r_Rx). Both FFs reset to 1. The FSM uses only r_Rx.
- H = (CLKS_PER_BIT-1)/2 (integer division; 108 at default). The bit counter is 32-bit and resets to 0 on every state change.
- IDLE: counter cleared. r_Rx==0 → START.
- START: count to H. At count==H:
  - sample 0 → DATA, bit index 0.
  - sample 1 → IDLE as a glitch/false start. No output pulse.
- DATA: count to CLKS_PER_BIT-1. At that count, sample into byte bit [index], index++. After index 7 → STOP.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - Sample 1: o_Rx_Byte ← shift data, o_Rx_DV=1 for one cycle.
  - Sample 0: o_Rx_Byte ← data anyway, o_Rx_Frame_Err=1 for one cycle.
  - Either way → CLEANUP.
- CLEANUP: stays here while r_Rx==0 (break / stuck-low line), so a frame error cannot retrigger START. → IDLE on the first cycle r_Rx==1. o_Rx_Active is low here.
- o_Rx_DV and o_Rx_Frame_Err are never high in the same cycle.
- Reset, including mid-frame: FSM → IDLE; counter and index 0; o_Rx_Byte=8'h00; o_Rx_DV=0; o_Rx_Active=0; o_Rx_Frame_Err=0; synchronizer = 1. The partial frame is discarded.

## Timing
- Edge k is the first rising edge at which the low start level is present on i_Rx_Serial.
- FSM enters START after edge k+2.
- Start bit is checked at edge k+3+H.
- Data bit n is sampled at edge k+3+H+(n+1)·CLKS_PER_BIT.
- Stop bit is sampled at edge k+3+H+9·CLKS_PER_BIT (k+2064 at default). o_Rx_DV / o_Rx_Frame_Err and the new o_Rx_Byte are visible in the following cycle.
- o_Rx_Active rises after edge k+2. It falls in the same cycle as the DV/Err pulse.
- Back-to-back frames: the next start edge may arrive immediately after the stop-bit sample. It is detected because CLEANUP exits on r_Rx==1 in one cycle and the remaining half stop bit is high.
- No back-pressure: the consumer must take o_Rx_Byte within one frame time.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Every sample decision (start check, data, stop) is the 2-of-3 majority of r_Rx captured at counts T-2, T-1 and T, where T is the decision count.
  - Decision edges are unchanged, so the latency figures above still hold.
- Undefined: single sample of r_Rx at count T.

## Test plan
- Reset/idle: i_Reset high 3 cycles, line high → all outputs 0 and o_Rx_Byte=8'h00. No DV over 5000 cycles.
- Single frame: drive 8'hA5 at 217 clk/bit → o_Rx_DV one cycle at k+2065, o_Rx_Byte=8'hA5, o_Rx_Frame_Err=0. o_Rx_Active high for exactly the frame.
- Back-to-back: 8'h00, 8'hFF, 8'h3C with no idle gap → three DV pulses with bytes in order, no frame errors.
- False start: line low for 50 cycles then high → return to IDLE, no DV, no Err, o_Rx_Active drops after the check edge.
- Framing error / break: 8'h55 with stop bit low, line held low 3000 cycles, then high → one Err pulse, o_Rx_Byte=8'h55, no DV. Normal 8'h12 frame afterwards is received correctly.
- Reset mid-frame: assert i_Reset during data bit 4 of 8'hC3 → no DV. Next full frame 8'h81 → DV with 8'h81. Under UART_RX_MAJORITY_EN, a 1-cycle glitch at each data-bit centre does not corrupt 8'h81.
